// File: rtl/multiplier_pkg.sv
// Shared widths, iteration counts and Booth digit helpers for the iterative multiplier.
// Define MULTIPLIER_RADIX4_EN for radix-4 recoding (2 product bits per step).
package multiplier_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

`ifdef MULTIPLIER_RADIX4_EN
    localparam int EXT_W   = 34;
    localparam int ITER_N  = 17;
    localparam int SHIFT_W = 2;
    localparam int GUARD_W = 2;
`else
    localparam int EXT_W   = 33;
    localparam int ITER_N  = 33;
    localparam int SHIFT_W = 1;
    localparam int GUARD_W = 1;
`endif

    // Accumulator headroom covers the largest digit (2M in radix-4) without overflow.
    localparam int A_W   = EXT_W + GUARD_W;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] ITER    = CNT_W'(ITER_N);
    localparam logic [CNT_W-1:0] CNT_ONE = 6'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_M1   = 3'd2,
        BD_P2   = 3'd3,
        BD_M2   = 3'd4
    } booth_digit_e;

    function automatic booth_digit_e booth_decode(input logic [2:0] bits);
        booth_digit_e digit;
`ifdef MULTIPLIER_RADIX4_EN
        case (bits)
            3'b001, 3'b010: digit = BD_P1;
            3'b011:         digit = BD_P2;
            3'b100:         digit = BD_M2;
            3'b101, 3'b110: digit = BD_M1;
            default:        digit = BD_ZERO;
        endcase
`else
        case (bits)
            3'b001:  digit = BD_P1;
            3'b010:  digit = BD_M1;
            default: digit = BD_ZERO;
        endcase
`endif
        return digit;
    endfunction

    function automatic logic [EXT_W-1:0] extend_operand(input logic [OP_W-1:0] v,
                                                        input logic          is_signed);
        return {{(EXT_W-OP_W){is_signed & v[OP_W-1]}}, v};
    endfunction

endpackage

// File: rtl/multiplier_booth_step.sv
// One combinational Booth step: add/subtract the recoded digit times M into A,
// then arithmetic-shift {A,Q,q-1} right by the radix width.
module multiplier_booth_step
    import multiplier_pkg::*;
(
    input  logic [A_W-1:0]   i_a,
    input  logic [EXT_W-1:0] i_m,
    input  logic [EXT_W-1:0] i_q,
    input  logic             i_q_m1,
    output logic [A_W-1:0]   o_a,
    output logic [EXT_W-1:0] o_q,
    output logic             o_q_m1
);

    logic [2:0]           w_bits;
    booth_digit_e         w_digit;
    logic [A_W-1:0]       w_m_ext;
    logic [A_W-1:0]       w_m2;
    logic [A_W-1:0]       w_sum;
    logic [A_W+EXT_W:0]   w_cat;
    logic [A_W+EXT_W:0]   w_shr;

`ifdef MULTIPLIER_RADIX4_EN
    assign w_bits = {i_q[1], i_q[0], i_q_m1};
`else
    assign w_bits = {1'b0, i_q[0], i_q_m1};
`endif

    // Digit selection, accumulate and shift.
    always_comb begin
        w_m_ext = {{(A_W-EXT_W){i_m[EXT_W-1]}}, i_m};
        w_m2    = {w_m_ext[A_W-2:0], 1'b0};
        w_digit = booth_decode(w_bits);
        case (w_digit)
            BD_ZERO: w_sum = i_a;
            BD_P1:   w_sum = i_a + w_m_ext;
            BD_M1:   w_sum = i_a - w_m_ext;
            BD_P2:   w_sum = i_a + w_m2;
            BD_M2:   w_sum = i_a - w_m2;
            default: w_sum = i_a;
        endcase
        w_cat = {w_sum, i_q, i_q_m1};
        w_shr = $signed(w_cat) >>> SHIFT_W;
    end

    assign o_a    = w_shr[A_W+EXT_W:EXT_W+1];
    assign o_q    = w_shr[EXT_W:1];
    assign o_q_m1 = w_shr[0];

endmodule

// File: rtl/multiplier.sv
// Sequential 32x32 -> 64 Booth multiplier: capture once after reset, iterate, hold result.
// Build option: MULTIPLIER_RADIX4_EN selects radix-4 recoding (fewer iterations).
module multiplier
    import multiplier_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [OP_W-1:0]   inputM,
    input  logic [OP_W-1:0]   inputQ,
    input  logic              input_plus,
    output logic [PROD_W-1:0] out
);

    state_e             r_state;
    state_e             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [A_W-1:0]     r_a;
    logic [EXT_W-1:0]   r_q;
    logic               r_q_m1;
    logic [EXT_W-1:0]   r_m;
    logic [PROD_W-1:0]  r_out;

    logic [A_W-1:0]     w_a;
    logic [EXT_W-1:0]   w_q;
    logic               w_q_m1;
    logic               w_last;

    multiplier_booth_step u_step (
        .i_a    (r_a),
        .i_m    (r_m),
        .i_q    (r_q),
        .i_q_m1 (r_q_m1),
        .o_a    (w_a),
        .o_q    (w_q),
        .o_q_m1 (w_q_m1)
    );

    assign w_last = (r_cnt == CNT_ONE);
    assign out    = r_out;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE is left only through reset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_next_state = ST_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (en && w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_DONE: w_next_state = ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and final product latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_a    <= {A_W{1'b0}};
            r_q    <= {EXT_W{1'b0}};
            r_q_m1 <= 1'b0;
            r_m    <= {EXT_W{1'b0}};
            r_out  <= {PROD_W{1'b0}};
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    r_m    <= extend_operand(inputM, input_plus);
                    r_q    <= extend_operand(inputQ, input_plus);
                    r_a    <= {A_W{1'b0}};
                    r_q_m1 <= 1'b0;
                    r_cnt  <= ITER;
                end
                ST_BUSY: begin
                    r_a    <= w_a;
                    r_q    <= w_q;
                    r_q_m1 <= w_q_m1;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (w_last) begin
                        r_out <= {w_a[PROD_W-EXT_W-1:0], w_q};
                    end
                end
                ST_DONE: begin
                    r_out <= r_out;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the Booth multiplier: expected products are queued at capture
// and compared when the enabled-edge latency has elapsed.
module tb_multiplier;

`ifdef MULTIPLIER_RADIX4_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [31:0] inputM = 32'd0;
    logic [31:0] inputQ = 32'd0;
    logic        input_plus = 1'b0;
    logic [63:0] out;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [63:0] last_exp;

    multiplier dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .inputM     (inputM),
        .inputQ     (inputQ),
        .input_plus (input_plus),
        .out        (out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q,
                                          input logic s);
        logic [63:0] a;
        logic [63:0] b;
        a = s ? {{32{m[31]}}, m} : {32'd0, m};
        b = s ? {{32{q[31]}}, q} : {32'd0, q};
        return a * b;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: out=%h expected=%h", tag, got, exp);
        end
    endtask

    // Pulse reset, present operands, queue the expected product, take the capture edge.
    task automatic start(input logic [31:0] m, input logic [31:0] q, input logic s);
        en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        inputM = m;
        inputQ = q;
        input_plus = s;
        sb.push_back(model(m, q, s));
        en = 1'b1;
        @(negedge clk);
    endtask

    // Run the given number of further enabled edges; out must be 0 before the last one.
    task automatic finish_op(input string tag, input int edges);
        en = 1'b1;
        repeat (edges - 1) @(negedge clk);
        check({tag, "_early"}, out, 64'd0);
        @(negedge clk);
        en = 1'b0;
        last_exp = sb.pop_front();
        check(tag, out, last_exp);
    endtask

    logic [31:0] tm [0:6];
    logic [31:0] tq [0:6];
    logic        ts [0:6];

    initial begin
        tm[0] = 32'h00087234; tq[0] = 32'h00000348; ts[0] = 1'b1;
        tm[1] = 32'h00087234; tq[1] = 32'hFFFFFEFD; ts[1] = 1'b1;
        tm[2] = 32'hB887CAAF; tq[2] = 32'h00000001; ts[2] = 1'b1;
        tm[3] = 32'hFFFFFEFD; tq[3] = 32'hFFFFFEFD; ts[3] = 1'b1;
        tm[4] = 32'hB887CAAF; tq[4] = 32'h887CAAF3; ts[4] = 1'b1;
        tm[5] = 32'h00000000; tq[5] = 32'h50647236; ts[5] = 1'b1;
        tm[6] = 32'hB887CAAF; tq[6] = 32'h887CAAF3; ts[6] = 1'b0;

        // Reset held with en high: nothing may happen.
        reset = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", out, 64'd0);

        for (int i = 0; i < 7; i++) begin
            start(tm[i], tq[i], ts[i]);
            finish_op($sformatf("vec%0d", i), LAT - 1);
        end

        // DONE ignores en and operand changes.
        en = 1'b1;
        inputM = 32'h12345678;
        inputQ = 32'h9ABCDEF0;
        input_plus = 1'b1;
        repeat (5) @(negedge clk);
        check("done_hold", out, last_exp);

        // Corner products with fixed expectations.
        start(32'h80000000, 32'h80000000, 1'b1);
        void'(sb.pop_back());
        sb.push_back(64'h4000000000000000);
        finish_op("min_sq_signed", LAT - 1);
        start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        void'(sb.pop_back());
        sb.push_back(64'hFFFFFFFE00000001);
        finish_op("max_sq_unsigned", LAT - 1);

        // Random operands in both signedness modes.
        for (int i = 0; i < 4; i++) begin
            start($urandom, $urandom, 1'(i % 2));
            finish_op($sformatf("rand%0d", i), LAT - 1);
        end

        // Ten disabled cycles mid-operation freeze everything.
        start(32'h50647236, 32'h50612336, 1'b1);
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_out", out, 64'd0);
        finish_op("stall", LAT - 5);

        // Operand changes after capture are ignored.
        start(32'h50647236, 32'h50612336, 1'b1);
        inputM = 32'hFFFFFFFF;
        inputQ = 32'h00000007;
        input_plus = 1'b0;
        finish_op("late_inputs", LAT - 1);

        // Asynchronous reset from DONE clears out without a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", out, 64'd0);
        @(negedge clk);

        // Reset mid-operation, then a full fresh run.
        start(32'h50647236, 32'h50612336, 1'b1);
        repeat (10) @(negedge clk);
        void'(sb.pop_front());
        start(32'h50647236, 32'h50612336, 1'b1);
        finish_op("after_abort", LAT - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
